data_connection_config_loader: RTL and testbench



---
 rtl/data_connection_config_loader_pkg.sv | 36 +++
 rtl/data_connection_config_loader_cb_output_conflict_check.sv | 36 +++
 rtl/data_connection_config_loader.sv | 149 ++++++++++++++
 tb/tb_data_connection_config_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_connection_config_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_connection_config_loader_pkg
// Description : Shared types and sizing helpers for the connection-block
//               configuration loader: frame geometry, counter width and the
//               loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package data_connection_config_loader_pkg;

   // Loader states; explicit 3-bit encoding.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_CSUM   = 3'd2,
      ST_CHECK  = 3'd3,
      ST_COMMIT = 3'd4
   } state_t;

   // Total switch-enable bits in one tile.
   function automatic int calc_nbits(input int w, input int din, input int dout);
      return w * (din + dout);
   endfunction

   // Data words per frame (last word may carry pad bits).
   function automatic int calc_nwords(input int nbits, input int cw);
      return (nbits + cw - 1) / cw;
   endfunction

   // Word counter must be able to hold NWORDS itself.
   function automatic int calc_cnt_w(input int nwords);
      return $clog2(nwords + 1);
   endfunction

endpackage : data_connection_config_loader_pkg
`default_nettype wire

// File: rtl/data_connection_config_loader_cb_output_conflict_check.sv
`default_nettype none
// ============================================================================
// Module      : cb_output_conflict_check
// Description : Combinational detector for routing-track contention between
//               output pin groups. Flags when any track is enabled in two or
//               more of the DATAOUT output groups.
// Ports       : i_out_field - DATAOUT*W enables, group i at [i*W +: W]
//               o_conflict  - 1 when at least one track is multiply driven
// Revision    : 1.0 - initial release
// ============================================================================
module cb_output_conflict_check
   import data_connection_config_loader_pkg::*;
#(
   parameter int W       = 16,
   parameter int DATAOUT = 3
) (
   input  logic [DATAOUT*W-1:0] i_out_field,
   output logic                 o_conflict
);

   logic [W-1:0] w_seen;   // track enabled by at least one group so far
   logic [W-1:0] w_multi;  // track enabled by two or more groups

   // Running "seen once" / "seen twice" per track avoids a per-track adder.
   always_comb begin
      w_seen  = '0;
      w_multi = '0;
      for (int i = 0; i < DATAOUT; i++) begin
         w_multi = w_multi | (w_seen & i_out_field[i*W +: W]);
         w_seen  = w_seen  | i_out_field[i*W +: W];
      end
      o_conflict = |w_multi;
   end

endmodule : cb_output_conflict_check
`default_nettype wire

// File: rtl/data_connection_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : data_connection_config_loader
// Description : Word-serial configuration loader for one data_connection_block
//               tile. Collects a frame into a shadow register, validates the
//               XOR checksum and output-track exclusivity, then atomically
//               updates the active switch-enable vector c.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               cfg_start         - begin / restart a frame
//               cfg_valid/cfg_data/cfg_ready - word handshake
//               c                 - active switch enables (inputs low, outputs high)
//               cfg_busy          - frame in progress
//               cfg_done          - one-cycle commit pulse
//               cfg_err           - sticky reject flag for the last frame
// Revision    : 1.0 - initial release
// ============================================================================
module data_connection_config_loader
   import data_connection_config_loader_pkg::*;
#(
   parameter int W       = 16,
   parameter int DATAIN  = 4,
   parameter int DATAOUT = 3,
   parameter int CW      = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            cfg_start,
   input  logic                            cfg_valid,
   input  logic [CW-1:0]                   cfg_data,
   output logic                            cfg_ready,
   output logic [W*(DATAIN+DATAOUT)-1:0]   c,
   output logic                            cfg_busy,
   output logic                            cfg_done,
   output logic                            cfg_err
);

   localparam int c_nbits   = calc_nbits(W, DATAIN, DATAOUT);
   localparam int c_nwords  = calc_nwords(c_nbits, CW);
   localparam int c_cnt_w   = calc_cnt_w(c_nwords);
   localparam int c_sh_bits = c_nwords * CW;

   state_t                 r_state;
   logic [c_cnt_w-1:0]     r_cnt;
   logic [c_sh_bits-1:0]   r_shadow;
   logic [CW-1:0]          r_xor;
   logic [CW-1:0]          r_csum;
   logic [c_nbits-1:0]     r_c;
   logic                   r_ready;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_err;

   logic                   w_acc;
   logic                   w_conflict;
   logic                   w_csum_ok;

   assign w_acc     = cfg_valid & r_ready;
   assign w_csum_ok = (r_xor == r_csum);

   cb_output_conflict_check #(
      .W       (W),
      .DATAOUT (DATAOUT)
   ) u_conflict (
      .i_out_field (r_shadow[c_nbits-1:W*DATAIN]),
      .o_conflict  (w_conflict)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_shadow <= '0;
         r_xor    <= '0;
         r_csum   <= '0;
         r_c      <= '0;
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cfg_start) begin
                  r_shadow <= '0;
                  r_cnt    <= '0;
                  r_xor    <= '0;
                  r_err    <= 1'b0;
                  r_ready  <= 1'b1;
                  r_busy   <= 1'b1;
                  r_state  <= ST_LOAD;
               end
            end
            ST_LOAD, ST_CSUM: begin
               // A start always wins over a simultaneous word.
               if (cfg_start) begin
                  r_shadow <= '0;
                  r_cnt    <= '0;
                  r_xor    <= '0;
                  r_state  <= ST_LOAD;
               end else if (w_acc && (r_state == ST_LOAD)) begin
                  for (int k = 0; k < c_nwords; k++) begin
                     if (r_cnt == c_cnt_w'(k))
                        r_shadow[k*CW +: CW] <= cfg_data;
                  end
                  r_xor <= r_xor ^ cfg_data;
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == c_cnt_w'(c_nwords - 1))
                     r_state <= ST_CSUM;
               end else if (w_acc) begin
                  r_csum  <= cfg_data;
                  r_ready <= 1'b0;
                  r_state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               // c is loaded on the CHECK->COMMIT edge so it appears together
               // with the done pulse.
               if (w_csum_ok && !w_conflict) begin
                  r_c     <= r_shadow[c_nbits-1:0];
                  r_done  <= 1'b1;
                  r_state <= ST_COMMIT;
               end else begin
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_COMMIT: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cfg_ready = r_ready;
   assign cfg_busy  = r_busy;
   assign cfg_done  = r_done;
   assign cfg_err   = r_err;
   assign c         = r_c;

endmodule : data_connection_config_loader
`default_nettype wire

// File: tb/tb_data_connection_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_connection_config_loader
// Description : Self-checking bench for the configuration loader. Directed
//               frames plus randomized frames with handshake gaps, compared
//               against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_connection_config_loader;

   localparam int TW    = 16;
   localparam int TDIN  = 4;
   localparam int TDOUT = 3;
   localparam int TCW   = 8;
   localparam int NB    = TW * (TDIN + TDOUT);
   localparam int NW    = (NB + TCW - 1) / TCW;

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_start;
   logic          cfg_valid;
   logic [7:0]    cfg_data;
   logic          cfg_ready;
   logic [NB-1:0] c;
   logic          cfg_busy;
   logic          cfg_done;
   logic          cfg_err;

   int total = 0;
   int bad   = 0;

   logic [7:0]    fr [NW];
   logic [7:0]    csum_w;
   logic [NB-1:0] model_c;

   data_connection_config_loader #(
      .W       (TW),
      .DATAIN  (TDIN),
      .DATAOUT (TDOUT),
      .CW      (TCW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_data  (cfg_data),
      .cfg_ready (cfg_ready),
      .c         (c),
      .cfg_busy  (cfg_busy),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: the frame's data bits laid out word 0 first.
   function automatic logic [NB-1:0] frame_bits();
      logic [NB-1:0] v;
      v = '0;
      for (int k = 0; k < NW; k++)
         for (int b = 0; b < TCW; b++)
            if (k*TCW + b < NB) v[k*TCW + b] = fr[k][b];
      return v;
   endfunction

   // Reference: accept iff XOR checksum holds and no track has >1 output driver.
   function automatic logic frame_ok();
      logic [7:0]    x;
      logic [NB-1:0] v;
      int            n;
      x = 8'h00;
      for (int k = 0; k < NW; k++) x = x ^ fr[k];
      if (x != csum_w) return 1'b0;
      v = frame_bits();
      for (int j = 0; j < TW; j++) begin
         n = 0;
         for (int i = 0; i < TDOUT; i++)
            n = n + int'(v[TW*TDIN + i*TW + j]);
         if (n > 1) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic send_word(input logic [7:0] d);
      int gaps;
      gaps = $urandom_range(0, 2);
      repeat (gaps) begin
         cfg_valid = 1'b0;
         cfg_data  = 8'($urandom);
         tick();
      end
      cfg_valid = 1'b1;
      cfg_data  = d;
      chk("ready_in_frame", cfg_ready, 1'b1);
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic partial(input int n, input logic [7:0] d);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      for (int k = 0; k < n; k++) send_word(d);
      chk("partial_c_held", c, model_c);
   endtask

   // Full frame from fr/csum_w; optional start+valid collision before word
   // collide_at, optional start pulse during the check cycle.
   task automatic run_frame(input int collide_at, input logic poke_start);
      logic [NB-1:0] prev;
      logic          ok;
      prev = model_c;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      chk("start_ready", cfg_ready, 1'b1);
      chk("start_busy", cfg_busy, 1'b1);
      if (collide_at >= 0) begin
         for (int k = 0; k < collide_at; k++) send_word(fr[k]);
         cfg_start = 1'b1;
         cfg_valid = 1'b1;
         cfg_data  = 8'hFF;
         tick();
         cfg_start = 1'b0;
         cfg_valid = 1'b0;
         chk("collide_busy", cfg_busy, 1'b1);
      end
      for (int k = 0; k < NW; k++) send_word(fr[k]);
      send_word(csum_w);
      // T+1: check cycle; a word offered here must be ignored.
      chk("check_ready", cfg_ready, 1'b0);
      chk("check_busy", cfg_busy, 1'b1);
      chk("check_c_held", c, prev);
      cfg_valid = 1'b1;
      cfg_data  = 8'($urandom);
      cfg_start = poke_start;
      tick();
      cfg_valid = 1'b0;
      cfg_start = 1'b0;
      // T+2
      ok = frame_ok();
      if (ok) model_c = frame_bits();
      chk("t2_c", c, model_c);
      chk("t2_done", cfg_done, ok);
      chk("t2_err", cfg_err, !ok);
      chk("t2_busy", cfg_busy, ok);
      tick();
      // T+3
      chk("t3_done", cfg_done, 1'b0);
      chk("t3_busy", cfg_busy, 1'b0);
      chk("t3_ready", cfg_ready, 1'b0);
      chk("t3_c", c, model_c);
   endtask

   task automatic clear_frame();
      for (int k = 0; k < NW; k++) fr[k] = 8'h00;
      csum_w = 8'h00;
   endtask

   task automatic gen_random();
      logic [NB-1:0] v;
      logic [7:0]    x;
      int            g;
      for (int k = 0; k < NB; k++) v[k] = 1'($urandom);
      if ($urandom_range(0, 2) != 0) begin
         v[NB-1:TW*TDIN] = '0;
         for (int j = 0; j < TW; j++) begin
            g = $urandom_range(0, TDOUT);
            if (g < TDOUT) v[TW*TDIN + g*TW + j] = 1'b1;
         end
      end
      x = 8'h00;
      for (int k = 0; k < NW; k++) begin
         fr[k] = v[k*TCW +: TCW];
         x = x ^ fr[k];
      end
      csum_w = ($urandom_range(0, 3) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x;
   endtask

   initial begin
      reset     = 1'b1;
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = 8'h00;
      model_c   = '0;
      repeat (2) tick();
      reset = 1'b0;
      chk("rst_c", c, '0);
      chk("rst_ready", cfg_ready, 1'b0);
      chk("rst_busy", cfg_busy, 1'b0);
      chk("rst_done", cfg_done, 1'b0);
      chk("rst_err", cfg_err, 1'b0);

      // Good frame: c becomes 1.
      clear_frame();
      fr[0] = 8'h01; csum_w = 8'h01;
      run_frame(-1, 1'b0);
      chk("good_c_literal", c, 1);

      // Bad checksum: error, c held.
      csum_w = 8'h00;
      run_frame(-1, 1'b0);
      chk("badcs_c_literal", c, 1);

      // Output conflict on track 0 between output groups 0 and 1.
      clear_frame();
      fr[8] = 8'h01; fr[10] = 8'h01;
      run_frame(-1, 1'b0);
      chk("conflict_err", cfg_err, 1'b1);

      // Abort then restart: only bit 31 set.
      partial(5, 8'hFF);
      clear_frame();
      fr[3] = 8'h80; csum_w = 8'h80;
      run_frame(-1, 1'b0);
      chk("abort_c_literal", c, 128'h8000_0000);

      // Collision of start and valid, plus start during the check cycle.
      gen_random();
      run_frame(4, 1'b1);

      // Randomized frames.
      for (int f = 0; f < 10; f++) begin
         gen_random();
         run_frame(($urandom_range(0, 3) == 0) ? $urandom_range(0, NW-1) : -1,
                   1'($urandom_range(0, 1)));
      end

      // Reset mid-frame clears committed c.
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      for (int k = 0; k < 3; k++) send_word(8'h5A);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_c = '0;
      chk("midrst_c", c, '0);
      chk("midrst_busy", cfg_busy, 1'b0);
      chk("midrst_ready", cfg_ready, 1'b0);
      chk("midrst_err", cfg_err, 1'b0);

      // Recovery after reset.
      clear_frame();
      fr[NW-1] = 8'hC3; csum_w = 8'hC3;
      run_frame(-1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_data_connection_config_loader
`default_nettype wire
